payload_char_decoder: RTL and testbench

PAYLOAD_CHAR_DECODER -- requirements
Module: payload_char_decoder

---
 rtl/payload_char_decoder_if.sv | 12 +
 rtl/payload_char_decoder.sv | 121 ++++++++++++
 tb/tb_payload_char_decoder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/payload_char_decoder_if.sv
// Byte stream from the packet source into the payload character decoder.
// Ports: s_data/s_valid/s_last flow source -> decoder; s_ready flows back.
// Backpressure: a byte moves only on a clock edge where s_valid and s_ready are both high.
interface payload_char_decoder_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/payload_char_decoder.sv
// Purpose: frames payload bytes for a regex engine: sod clear, per-byte enable with
//   character class bits, eop sample strobe, byte count and truncation flag.
// Latency: byte accepted at edge k appears on byte_o/cls_o with en=1 in the cycle after k;
//   eop follows the final en by two cycles.
// Backpressure: s_ready is high only in RUN; IDLE, SOD and EOP stall the source.
// Ports: clk, rst (async, active-high); s (stream slave); sod, en, byte_o, cls_o,
//   eop, pay_len, trunc towards the engine and its consumers.
module payload_char_decoder #(
  parameter int MAX_LEN = 1460,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  payload_char_decoder_if.slave s,
  output logic                 sod,
  output logic                 en,
  output logic [7:0]           byte_o,
  output logic [5:0]           cls_o,
  output logic                 eop,
  output logic [CNT_W-1:0]     pay_len,
  output logic                 trunc
);

  typedef enum logic [1:0] {IDLE, SOD, RUN, EOP} state_t;

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           state, state_nxt;
  logic             ready;
  logic             accept;
  logic             eop_hold;   // second EOP cycle: the engine's settle cycle
  logic [CNT_W-1:0] cnt;

  // Class bits: [0] \s, [1] \w, [2] digit, [3] '(', [4] ')', [5] space.
  function automatic logic [5:0] char_class(input logic [7:0] b);
    logic ws, dig, wrd;
    ws  = ((b >= 8'h09) && (b <= 8'h0D)) || (b == 8'h20);
    dig = (b >= 8'h30) && (b <= 8'h39);
    wrd = dig || ((b >= 8'h41) && (b <= 8'h5A)) ||
          ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h5F);
    return {b == 8'h20, b == 8'h29, b == 8'h28, dig, wrd, ws};
  endfunction

  assign s.s_ready = ready;
  assign accept    = s.s_valid && ready;
  assign pay_len   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    sod       = 1'b0;
    case (state)
      IDLE: if (s.s_valid) state_nxt = SOD;
      SOD: begin
        sod       = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        ready = 1'b1;
        if (s.s_valid && s.s_last) state_nxt = EOP;
      end
      EOP: if (eop_hold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // en, cls_o and eop are single-cycle strobes, so they default low every cycle;
  // byte_o holds its last forwarded value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      byte_o   <= '0;
      cls_o    <= '0;
      eop      <= 1'b0;
      trunc    <= 1'b0;
      cnt      <= '0;
      eop_hold <= 1'b0;
    end else begin
      en  <= 1'b0;
      cls_o <= '0;
      eop <= 1'b0;
      case (state)
        SOD: begin
          cnt      <= '0;
          trunc    <= 1'b0;
          eop_hold <= 1'b0;
        end
        RUN: begin
          eop_hold <= 1'b0;
          if (accept) begin
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
            // Bytes past MAX_LEN are still counted and drained, only not forwarded.
            if (cnt < MAX_C) begin
              en     <= 1'b1;
              byte_o <= s.s_data;
              cls_o  <= char_class(s.s_data);
            end else begin
              trunc <= 1'b1;
            end
          end
        end
        EOP: begin
          if (eop_hold) begin
            eop      <= 1'b1;
            eop_hold <= 1'b0;
          end else begin
            eop_hold <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_char_decoder.sv
// Directed bench for payload_char_decoder (MAX_LEN=4 so truncation is reachable).
module tb_payload_char_decoder;

  logic        clk;
  logic        rst;
  logic        sod, en, eop, trunc;
  logic [7:0]  byte_o;
  logic [5:0]  cls_o;
  logic [15:0] pay_len;

  payload_char_decoder_if sif();

  payload_char_decoder #(.MAX_LEN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s(sif),
    .sod(sod), .en(en), .byte_o(byte_o), .cls_o(cls_o),
    .eop(eop), .pay_len(pay_len), .trunc(trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor: observes outputs on the falling edge only.
  int cyc = 0;
  int sod_cnt = 0, en_cnt = 0, eop_cnt = 0, overlap_cnt = 0, stray_cls_cnt = 0;
  int last_en_cyc = 0, eop_cyc = 0;
  logic [15:0] eop_len = '0;
  logic        eop_trunc = 1'b0;
  logic [7:0]  en_byte [$];
  logic [5:0]  en_cls [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sod) sod_cnt++;
    if (en) begin
      en_cnt++;
      en_byte.push_back(byte_o);
      en_cls.push_back(cls_o);
      last_en_cyc = cyc;
    end else if (cls_o != 6'd0) begin
      stray_cls_cnt++;
    end
    if (eop) begin
      eop_cnt++;
      eop_cyc = cyc;
      eop_len = pay_len;
      eop_trunc = trunc;
    end
    if (sod && en) overlap_cnt++;
  end

  int b_sod, b_en, b_eop, b_ovl, b_stray;

  task automatic snap();
    b_sod = sod_cnt; b_en = en_cnt; b_eop = eop_cnt;
    b_ovl = overlap_cnt; b_stray = stray_cls_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one byte and holds it until accepted (bounded).
  task automatic send_byte(input logic [7:0] d, input logic l);
    int w;
    logic ok;
    sif.s_data = d; sif.s_valid = 1'b1; sif.s_last = l;
    w = 0;
    do begin
      @(negedge clk); ok = sif.s_ready;
      @(posedge clk); w++;
    end while (!ok && w < 20);
    #1;
    sif.s_valid = 1'b0; sif.s_last = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_accept: byte %02h never accepted (ready=%0b, required 1)", d, ok);
    end
  endtask

  task automatic send_pkt(input logic [7:0] b [8], input int n);
    for (int i = 0; i < n; i++) send_byte(b[i], i == n - 1);
  endtask

  // Returns on the falling edge of the eop cycle.
  task automatic wait_eop();
    int w;
    w = 0;
    do begin @(negedge clk); w++; end while (!eop && w < 40);
    n_vec++;
    if (!eop) begin
      n_bad++;
      $display("FAIL eop_timeout: eop=%0b after %0d cycles, required 1", eop, w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.s_valid = 1'b1; sif.s_data = 8'h41; sif.s_last = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({sif.s_ready, sod, en, eop, trunc} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready/sod/en/eop/trunc=%05b required 00000",
               {sif.s_ready, sod, en, eop, trunc});
    end
    n_vec++;
    if ({byte_o, cls_o, pay_len} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_data: byte=%02h cls=%02h len=%0d required 0/0/0", byte_o, cls_o, pay_len);
    end
    sif.s_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    idle(2);
  endtask

  task automatic test_paren();
    logic [7:0] b [8] = '{8'h28, 8'h61, 8'h62, 8'h29, 0, 0, 0, 0};
    logic [5:0] c [4] = '{6'h08, 6'h02, 6'h02, 6'h10};
    int q;
    q = en_byte.size();
    snap();
    send_pkt(b, 4);
    wait_eop();
    idle(3);
    n_vec++;
    if (sod_cnt - b_sod !== 1) begin n_bad++; $display("FAIL paren_sod: %0d sod cycles, required 1", sod_cnt - b_sod); end
    n_vec++;
    if (en_cnt - b_en !== 4) begin n_bad++; $display("FAIL paren_en: %0d en cycles, required 4", en_cnt - b_en); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (en_byte[q+i] !== b[i] || en_cls[q+i] !== c[i]) begin
        n_bad++;
        $display("FAIL paren_byte%0d: byte=%02h cls=%02h required %02h/%02h", i, en_byte[q+i], en_cls[q+i], b[i], c[i]);
      end
    end
    n_vec++;
    if (eop_cnt - b_eop !== 1) begin n_bad++; $display("FAIL paren_eop: %0d eop pulses, required 1", eop_cnt - b_eop); end
    n_vec++;
    if (eop_cyc - last_en_cyc !== 2) begin n_bad++; $display("FAIL paren_eop_gap: eop %0d cycles after last en, required 2", eop_cyc - last_en_cyc); end
    n_vec++;
    if (eop_len !== 16'd4 || eop_trunc !== 1'b0) begin
      n_bad++; $display("FAIL paren_len: pay_len=%0d trunc=%0b required 4/0", eop_len, eop_trunc);
    end
    n_vec++;
    if (overlap_cnt - b_ovl !== 0) begin n_bad++; $display("FAIL paren_overlap: sod&en seen %0d times, required 0", overlap_cnt - b_ovl); end
  endtask

  task automatic test_classes();
    logic [7:0] b [8] = '{8'h20, 8'h09, 8'h5F, 8'h37, 0, 0, 0, 0};
    logic [5:0] c [4] = '{6'h21, 6'h01, 6'h02, 6'h06};
    int q;
    q = en_byte.size();
    send_pkt(b, 4);
    wait_eop();
    idle(3);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (en_cls[q+i] !== c[i]) begin
        n_bad++;
        $display("FAIL class_%02h: cls=%02h required %02h", b[i], en_cls[q+i], c[i]);
      end
    end
  endtask

  task automatic test_trunc();
    logic [7:0] b [8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 0, 0};
    int q;
    q = en_byte.size();
    snap();
    send_pkt(b, 6);
    wait_eop();
    idle(3);
    n_vec++;
    if (en_cnt - b_en !== 4) begin n_bad++; $display("FAIL trunc_en: %0d en cycles, required 4", en_cnt - b_en); end
    n_vec++;
    if (en_byte[q+3] !== 8'h44) begin n_bad++; $display("FAIL trunc_lastbyte: %02h required 44", en_byte[q+3]); end
    n_vec++;
    if (eop_len !== 16'd6 || eop_trunc !== 1'b1) begin
      n_bad++; $display("FAIL trunc_len: pay_len=%0d trunc=%0b required 6/1", eop_len, eop_trunc);
    end
    n_vec++;
    if (eop_cnt - b_eop !== 1) begin n_bad++; $display("FAIL trunc_eop: %0d eop pulses, required 1", eop_cnt - b_eop); end
  endtask

  task automatic test_gaps();
    snap();
    send_byte(8'h31, 1'b0);
    idle(2);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b1);
    wait_eop();
    idle(3);
    n_vec++;
    if (en_cnt - b_en !== 3) begin n_bad++; $display("FAIL gaps_en: %0d en cycles, required 3", en_cnt - b_en); end
    n_vec++;
    if (stray_cls_cnt - b_stray !== 0) begin n_bad++; $display("FAIL gaps_cls: %0d cycles cls!=0 without en, required 0", stray_cls_cnt - b_stray); end
    n_vec++;
    if (eop_cnt - b_eop !== 1 || eop_len !== 16'd3 || eop_trunc !== 1'b0) begin
      n_bad++; $display("FAIL gaps_eop: eops=%0d pay_len=%0d trunc=%0b required 1/3/0", eop_cnt - b_eop, eop_len, eop_trunc);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [8] = '{8'h78, 8'h79, 8'h7A, 0, 0, 0, 0, 0};
    snap();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    #2; rst = 1'b1; #1;
    n_vec++;
    if ({sif.s_ready, sod, en, eop, trunc} !== 5'b0 || {byte_o, cls_o, pay_len} !== 30'd0) begin
      n_bad++;
      $display("FAIL rstmid_async: ctl=%05b byte=%02h cls=%02h len=%0d required all 0",
               {sif.s_ready, sod, en, eop, trunc}, byte_o, cls_o, pay_len);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({sod, en, eop} !== 3'b0) begin n_bad++; $display("FAIL rstmid_release: sod/en/eop=%03b required 000", {sod, en, eop}); end
    idle(6);
    n_vec++;
    if (eop_cnt - b_eop !== 0) begin n_bad++; $display("FAIL rstmid_noeop: %0d eop pulses, required 0", eop_cnt - b_eop); end
    snap();
    send_pkt(b, 3);
    wait_eop();
    idle(3);
    n_vec++;
    if (sod_cnt - b_sod !== 1 || en_cnt - b_en !== 3) begin
      n_bad++; $display("FAIL rstmid_next: sod=%0d en=%0d required 1/3", sod_cnt - b_sod, en_cnt - b_en);
    end
    n_vec++;
    if (eop_len !== 16'd3) begin n_bad++; $display("FAIL rstmid_len: pay_len=%0d required 3", eop_len); end
  endtask

  task automatic test_back_to_back();
    int q;
    q = en_byte.size();
    snap();
    send_byte(8'h41, 1'b1);
    wait_eop();
    send_byte(8'h42, 1'b1);   // s_valid raised during the eop cycle
    wait_eop();
    idle(3);
    n_vec++;
    if (sod_cnt - b_sod !== 2 || eop_cnt - b_eop !== 2) begin
      n_bad++; $display("FAIL b2b_pulses: sod=%0d eop=%0d required 2/2", sod_cnt - b_sod, eop_cnt - b_eop);
    end
    n_vec++;
    if (en_cnt - b_en !== 2 || en_byte[q+1] !== 8'h42) begin
      n_bad++; $display("FAIL b2b_en: en=%0d second byte=%02h required 2/42", en_cnt - b_en, en_byte[q+1]);
    end
    n_vec++;
    if (overlap_cnt - b_ovl !== 0 || eop_len !== 16'd1) begin
      n_bad++; $display("FAIL b2b_overlap: sod&en=%0d pay_len=%0d required 0/1", overlap_cnt - b_ovl, eop_len);
    end
  endtask

  initial begin
    sif.s_data = 8'h00; sif.s_valid = 1'b0; sif.s_last = 1'b0;
    test_reset();
    test_paren();
    test_classes();
    test_trunc();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
